// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-stage data access unit. Turns the effective address and
//            store data from execute into a single-outstanding request on an
//            SRAM-like bus (req / addr_ok / data_ok). It stalls the pipeline
//            until the access completes, returns the sign/zero-extended or
//            merged load value, and flags misaligned loads and stores.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   KSEG_MAP       1: vaddr 0x8000_0000-0xBFFF_FFFF maps to vaddr & 0x1FFF_FFFF
//                  0: paddr = vaddr
// Build option
//   MEM_UNALIGNED_EN  when defined, mem_size 4/5 (LWL/LWR, SWL/SWR) are
//                     executed as word-aligned accesses with lane merging.
//                     When undefined, mem_size 4..7 are ignored.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, mem_read,       instruction present, load, store,
//   mem_write, mem_size,      access size (0 B, 1 H, 2 W, 4 L, 5 R),
//   mem_unsigned              zero-extend loaded byte/half
//   addr, wdata               effective vaddr, store data / merge source
//   flush                     kill the instruction in this stage
//   stall                     hold upstream stages
//   rdata, rdata_valid        load result, one-cycle completion pulse
//   addr_err_load/_store,     misaligned access flags (combinational),
//   badvaddr                  faulting address
//   data_req, data_wr,        bus request, write, size (0 B, 1 H, 2 W),
//   data_size, data_addr,     physical address,
//   data_wdata, data_wstrb    replicated store data, byte strobes
//   data_addr_ok,             request accepted,
//   data_data_ok, data_rdata  read data valid / write done, read data
// ============================================================================
module mem_access #(
    parameter int KSEG_MAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err_load,
    output logic        addr_err_store,
    output logic [31:0] badvaddr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] c_SZ_BYTE = 3'd0;
    localparam logic [2:0] c_SZ_HALF = 3'd1;
    localparam logic [2:0] c_SZ_WORD = 3'd2;
`ifdef MEM_UNALIGNED_EN
    localparam logic [2:0] c_SZ_LEFT  = 3'd4;
    localparam logic [2:0] c_SZ_RIGHT = 3'd5;
`endif

    // ------------------------------------------------------------------
    // State and registered request / response fields
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic [3:0]  data_wstrb_q, data_wstrb_d;
    logic [1:0]  data_size_q, data_size_d;
    logic        data_wr_q, data_wr_d;
    logic [31:0] rdata_q, rdata_d;
    // Load-formatting context captured at accept
    logic [2:0]  op_size_q, op_size_d;
    logic        op_unsigned_q, op_unsigned_d;
    logic [1:0]  op_lane_q, op_lane_d;
`ifdef MEM_UNALIGNED_EN
    logic [31:0] merge_q, merge_d;
`endif

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic        w_misalign;
    logic        w_size_ok;
    logic        w_accept;
    logic [31:0] w_paddr;
    logic [1:0]  w_lane;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_wstrb;
    logic [1:0]  w_req_size;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_result;

    assign w_misalign = ((mem_size == c_SZ_HALF) && addr[0]) ||
                        ((mem_size == c_SZ_WORD) && (addr[1:0] != 2'b00));

`ifdef MEM_UNALIGNED_EN
    assign w_size_ok = (mem_size <= c_SZ_WORD) || (mem_size == c_SZ_LEFT) ||
                       (mem_size == c_SZ_RIGHT);
`else
    assign w_size_ok = (mem_size <= c_SZ_WORD);
`endif

    assign addr_err_load  = in_valid && mem_read  && w_misalign;
    assign addr_err_store = in_valid && mem_write && w_misalign;
    assign badvaddr       = addr;

    assign w_accept = in_valid && (mem_read || mem_write) && w_size_ok &&
                      !w_misalign && !flush && (state_q == S_IDLE);

    // Unmapped kernel segments (kseg0/kseg1) drop the top three bits.
    always_comb begin
        w_paddr = addr;
        if ((KSEG_MAP != 0) && (addr[31:30] == 2'b10)) begin
            w_paddr = addr & 32'h1FFF_FFFF;
        end
    end

    assign w_lane = w_paddr[1:0];

    // Bus request fields for the instruction currently at the inputs.
    always_comb begin
        w_req_addr  = {w_paddr[31:2], 2'b00};
        w_req_size  = 2'd2;
        w_req_wdata = wdata;
        w_req_wstrb = 4'hF;
        case (mem_size)
            c_SZ_BYTE: begin
                w_req_addr  = w_paddr;
                w_req_size  = 2'd0;
                w_req_wdata = {4{wdata[7:0]}};
                w_req_wstrb = 4'b0001 << w_lane;
            end
            c_SZ_HALF: begin
                w_req_addr  = w_paddr;
                w_req_size  = 2'd1;
                w_req_wdata = {2{wdata[15:0]}};
                w_req_wstrb = 4'b0011 << w_lane;
            end
`ifdef MEM_UNALIGNED_EN
            // SWL: the most significant register bytes land in lanes 0..lane.
            c_SZ_LEFT: begin
                case (w_lane)
                    2'd0:    begin w_req_wdata = {24'h0, wdata[31:24]}; w_req_wstrb = 4'b0001; end
                    2'd1:    begin w_req_wdata = {16'h0, wdata[31:16]}; w_req_wstrb = 4'b0011; end
                    2'd2:    begin w_req_wdata = {8'h0,  wdata[31:8]};  w_req_wstrb = 4'b0111; end
                    default: begin w_req_wdata = wdata;                 w_req_wstrb = 4'b1111; end
                endcase
            end
            // SWR: the least significant register bytes land in lanes lane..3.
            c_SZ_RIGHT: begin
                case (w_lane)
                    2'd0:    begin w_req_wdata = wdata;                 w_req_wstrb = 4'b1111; end
                    2'd1:    begin w_req_wdata = {wdata[23:0], 8'h0};   w_req_wstrb = 4'b1110; end
                    2'd2:    begin w_req_wdata = {wdata[15:0], 16'h0};  w_req_wstrb = 4'b1100; end
                    default: begin w_req_wdata = {wdata[7:0], 24'h0};   w_req_wstrb = 4'b1000; end
                endcase
            end
`endif
            default: begin
                // Word access: address already aligned above.
            end
        endcase
        // Reads carry no data and no strobes.
        if (!mem_write) begin
            w_req_wdata = 32'h0;
            w_req_wstrb = 4'h0;
        end
    end

    // Load formatting from the captured lane / size context.
    assign w_ld_byte = data_rdata[{op_lane_q, 3'b000} +: 8];
    assign w_ld_half = op_lane_q[1] ? data_rdata[31:16] : data_rdata[15:0];

    always_comb begin
        w_load_result = data_rdata;
        case (op_size_q)
            c_SZ_BYTE: w_load_result = op_unsigned_q ? {24'h0, w_ld_byte}
                                                     : {{24{w_ld_byte[7]}}, w_ld_byte};
            c_SZ_HALF: w_load_result = op_unsigned_q ? {16'h0, w_ld_half}
                                                     : {{16{w_ld_half[15]}}, w_ld_half};
`ifdef MEM_UNALIGNED_EN
            // LWL: memory lanes 0..lane fill the top of the register.
            c_SZ_LEFT: begin
                case (op_lane_q)
                    2'd0:    w_load_result = {data_rdata[7:0],  merge_q[23:0]};
                    2'd1:    w_load_result = {data_rdata[15:0], merge_q[15:0]};
                    2'd2:    w_load_result = {data_rdata[23:0], merge_q[7:0]};
                    default: w_load_result = data_rdata;
                endcase
            end
            // LWR: memory lanes lane..3 fill the bottom of the register.
            c_SZ_RIGHT: begin
                case (op_lane_q)
                    2'd0:    w_load_result = data_rdata;
                    2'd1:    w_load_result = {merge_q[31:24], data_rdata[31:8]};
                    2'd2:    w_load_result = {merge_q[31:16], data_rdata[31:16]};
                    default: w_load_result = {merge_q[31:8],  data_rdata[31:24]};
                endcase
            end
`endif
            default: w_load_result = data_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        logic capture;
        capture       = 1'b0;
        state_d       = state_q;
        data_addr_d   = data_addr_q;
        data_wdata_d  = data_wdata_q;
        data_wstrb_d  = data_wstrb_q;
        data_size_d   = data_size_q;
        data_wr_d     = data_wr_q;
        rdata_d       = rdata_q;
        op_size_d     = op_size_q;
        op_unsigned_d = op_unsigned_q;
        op_lane_d     = op_lane_q;
`ifdef MEM_UNALIGNED_EN
        merge_d       = merge_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d       = S_REQ;
                    data_addr_d   = w_req_addr;
                    data_wdata_d  = w_req_wdata;
                    data_wstrb_d  = w_req_wstrb;
                    data_size_d   = w_req_size;
                    data_wr_d     = mem_write;
                    op_size_d     = mem_size;
                    op_unsigned_d = mem_unsigned;
                    op_lane_d     = w_lane;
`ifdef MEM_UNALIGNED_EN
                    merge_d       = wdata;
`endif
                end
            end
            S_REQ: begin
                if (flush) begin
                    // Not yet accepted, or already complete: nothing left
                    // in flight. Otherwise the response must be drained.
                    if (!data_addr_ok || data_data_ok) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = S_DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = flush ? S_IDLE : S_DONE;
                    capture = !flush;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (data_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture && !data_wr_q) begin
            rdata_d = w_load_result;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            data_addr_q   <= 32'h0;
            data_wdata_q  <= 32'h0;
            data_wstrb_q  <= 4'h0;
            data_size_q   <= 2'd0;
            data_wr_q     <= 1'b0;
            rdata_q       <= 32'h0;
            op_size_q     <= 3'd0;
            op_unsigned_q <= 1'b0;
            op_lane_q     <= 2'd0;
`ifdef MEM_UNALIGNED_EN
            merge_q       <= 32'h0;
`endif
        end else begin
            state_q       <= state_d;
            data_addr_q   <= data_addr_d;
            data_wdata_q  <= data_wdata_d;
            data_wstrb_q  <= data_wstrb_d;
            data_size_q   <= data_size_d;
            data_wr_q     <= data_wr_d;
            rdata_q       <= rdata_d;
            op_size_q     <= op_size_d;
            op_unsigned_q <= op_unsigned_d;
            op_lane_q     <= op_lane_d;
`ifdef MEM_UNALIGNED_EN
            merge_q       <= merge_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // DONE is deliberately excluded so the instruction retires that cycle.
    assign stall       = w_accept || (state_q == S_REQ) || (state_q == S_WAIT) ||
                         (state_q == S_DRAIN);
    assign data_req    = (state_q == S_REQ);
    assign rdata_valid = (state_q == S_DONE);
    assign rdata       = rdata_q;
    assign data_wr     = data_wr_q;
    assign data_size   = data_size_q;
    assign data_addr   = data_addr_q;
    assign data_wdata  = data_wdata_q;
    assign data_wstrb  = data_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Directed self-checking bench for mem_access. Inputs change on
//            the falling edge; outputs are sampled 1 ns later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, mem_unsigned, flush;
    logic [2:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, addr_err_load, addr_err_store;
    logic [31:0] rdata, badvaddr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .addr           (addr),
        .wdata          (wdata),
        .flush          (flush),
        .stall          (stall),
        .rdata          (rdata),
        .rdata_valid    (rdata_valid),
        .addr_err_load  (addr_err_load),
        .addr_err_store (addr_err_store),
        .badvaddr       (badvaddr),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_wstrb     (data_wstrb),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        in_valid     = v;
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
        flush        = 1'b0;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        data_addr_ok = aok;
        data_data_ok = dok;
        data_rdata   = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
    endtask

    // Accept in cycle 0, addr_ok+data_ok in cycle 1, completion in cycle 2.
    task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [2:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input logic [31:0] ex_addr,
                           input logic [31:0] ex_wdata, input logic [3:0] ex_strb,
                           input logic [1:0] ex_size, input logic [31:0] ex_rdata);
        drive(1'b1, rd, wr, sz, uns, a, wd);
        bus(1'b0, 1'b0, 32'h0);
        #1;
        check({tag, "_stall_accept"}, 32'(stall), 32'd1);
        @(negedge clk);
        bus(1'b1, 1'b1, rdat);
        #1;
        check({tag, "_req"},   32'(data_req),   32'd1);
        check({tag, "_addr"},  data_addr,       ex_addr);
        check({tag, "_wdata"}, data_wdata,      ex_wdata);
        check({tag, "_wstrb"}, 32'(data_wstrb), 32'(ex_strb));
        check({tag, "_size"},  32'(data_size),  32'(ex_size));
        check({tag, "_wr"},    32'(data_wr),    32'(wr));
        @(negedge clk);
        idle();
        #1;
        check({tag, "_rvalid"}, 32'(rdata_valid), 32'd1);
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        if (rd) check({tag, "_rdata"}, rdata, ex_rdata);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",    32'(data_req),    32'd0);
        check("rst_stall",  32'(stall),       32'd0);
        check("rst_rvalid", 32'(rdata_valid), 32'd0);
        check("rst_rdata",  rdata,            32'h0);
        check("rst_addr",   data_addr,        32'h0);
        check("rst_wstrb",  32'(data_wstrb),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LB from kseg0, single-cycle bus response
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h8000_0003, 32'h0);
        #1;
        check("lb_stall_c0", 32'(stall),    32'd1);
        check("lb_req_c0",   32'(data_req), 32'd0);
        @(negedge clk);
        bus(1'b1, 1'b1, 32'h80AA_BBCC);
        #1;
        check("lb_req_c1",   32'(data_req),   32'd1);
        check("lb_addr",     data_addr,       32'h0000_0003);
        check("lb_size",     32'(data_size),  32'd0);
        check("lb_wstrb",    32'(data_wstrb), 32'd0);
        check("lb_stall_c1", 32'(stall),      32'd1);
        @(negedge clk);
        idle();
        #1;
        check("lb_rvalid_c2", 32'(rdata_valid), 32'd1);
        check("lb_rdata",     rdata,            32'hFFFF_FF80);
        check("lb_stall_c2",  32'(stall),       32'd0);
        @(negedge clk);
        #1;
        check("lb_rvalid_c3", 32'(rdata_valid), 32'd0);
        @(negedge clk);

        // SH with addr_ok then data_ok a cycle later
        drive(1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 32'h1000_0002, 32'h0000_1234);
        #1;
        check("sh_stall_c0", 32'(stall), 32'd1);
        @(negedge clk);
        bus(1'b1, 1'b0, 32'h0);
        #1;
        check("sh_wdata", data_wdata,       32'h1234_1234);
        check("sh_wstrb", 32'(data_wstrb),  32'hC);
        check("sh_wr",    32'(data_wr),     32'd1);
        check("sh_size",  32'(data_size),   32'd1);
        check("sh_addr",  data_addr,        32'h1000_0002);
        @(negedge clk);
        bus(1'b0, 1'b1, 32'h0);
        #1;
        check("sh_req_wait",   32'(data_req),    32'd0);
        check("sh_stall_wait", 32'(stall),       32'd1);
        check("sh_rvalid_w",   32'(rdata_valid), 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("sh_rvalid", 32'(rdata_valid), 32'd1);
        check("sh_stall",  32'(stall),       32'd0);
        @(negedge clk);

        // Alignment errors
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0000_0006, 32'h0);
        #1;
        check("lw_err_load",  32'(addr_err_load),  32'd1);
        check("lw_err_store", 32'(addr_err_store), 32'd0);
        check("lw_badvaddr",  badvaddr,            32'h0000_0006);
        check("lw_err_stall", 32'(stall),          32'd0);
        @(negedge clk);
        #1;
        check("lw_err_noreq", 32'(data_req), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 32'h0000_0101, 32'h0);
        #1;
        check("sw_err_store", 32'(addr_err_store), 32'd1);
        check("sw_err_stall", 32'(stall),          32'd0);
        drive(1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 32'h0000_0003, 32'h0);
        #1;
        check("sh_err_store", 32'(addr_err_store), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0000_0002, 32'h0);
        #1;
        check("lh_ok_noerr", 32'(addr_err_load), 32'd0);
        idle();
        @(negedge clk);

        // LW with addr_ok in the 4th REQ cycle and data_ok two cycles later
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            drive((c < 7) ? 1'b1 : 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 32'h9000_0010, 32'h0);
            bus((c == 4) ? 1'b1 : 1'b0, (c == 6) ? 1'b1 : 1'b0, 32'hDEAD_BEEF);
            #1;
            check($sformatf("slow_req_c%0d", c), 32'(data_req),
                  (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            check($sformatf("slow_stall_c%0d", c), 32'(stall),
                  (c <= 6) ? 32'd1 : 32'd0);
            if (c == 1) check("slow_addr", data_addr, 32'h1000_0010);
            if (rdata_valid) pulses++;
            @(negedge clk);
        end
        check("slow_pulses", 32'(pulses), 32'd1);
        check("slow_rdata",  rdata,       32'hDEAD_BEEF);
        idle();

        // Flush while waiting for data, then a new LW held off by DRAIN
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge clk);
        bus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        idle();
        flush = 1'b1;
        #1;
        check("fw_stall_wait", 32'(stall), 32'd1);
        @(negedge clk);
        for (int c = 3; c <= 5; c++) begin
            drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0000_0024, 32'h0);
            bus(1'b0, (c == 5) ? 1'b1 : 1'b0, 32'h1234_5678);
            #1;
            check($sformatf("fw_stall_c%0d", c),  32'(stall),       32'd1);
            check($sformatf("fw_req_c%0d", c),    32'(data_req),    32'd0);
            check($sformatf("fw_rvalid_c%0d", c), 32'(rdata_valid), 32'd0);
            @(negedge clk);
        end
        bus(1'b0, 1'b0, 32'h0);
        #1;
        check("fw_accept_stall", 32'(stall),       32'd1);
        check("fw_accept_req",   32'(data_req),    32'd0);
        check("fw_rvalid_c6",    32'(rdata_valid), 32'd0);
        @(negedge clk);
        bus(1'b1, 1'b1, 32'hCAFE_F00D);
        #1;
        check("fw_new_req",  32'(data_req), 32'd1);
        check("fw_new_addr", data_addr,     32'h0000_0024);
        @(negedge clk);
        idle();
        #1;
        check("fw_new_rvalid", 32'(rdata_valid), 32'd1);
        check("fw_new_rdata",  rdata,            32'hCAFE_F00D);
        @(negedge clk);

        // Flush in REQ before addr_ok
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        idle();
        flush = 1'b1;
        #1;
        check("fr_req_c1", 32'(data_req), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fr_req_c2",    32'(data_req),    32'd0);
        check("fr_stall_c2",  32'(stall),       32'd0);
        check("fr_rvalid_c2", 32'(rdata_valid), 32'd0);
        @(negedge clk);
        #1;
        check("fr_rvalid_c3", 32'(rdata_valid), 32'd0);
        @(negedge clk);

        // Size, lane and address-map variety
        run_txn("lhu", 1'b1, 1'b0, 3'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h8765_4321,
                32'h0000_0002, 32'h0, 4'h0, 2'd1, 32'h0000_8765);
        run_txn("lh",  1'b1, 1'b0, 3'd1, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_F00F,
                32'h0000_0000, 32'h0, 4'h0, 2'd1, 32'hFFFF_F00F);
        run_txn("lbu", 1'b1, 1'b0, 3'd0, 1'b1, 32'h8000_0001, 32'h0, 32'h1234_AB78,
                32'h0000_0001, 32'h0, 4'h0, 2'd0, 32'h0000_00AB);
        run_txn("sb",  1'b0, 1'b1, 3'd0, 1'b0, 32'h0000_0005, 32'h0000_00AB, 32'h0,
                32'h0000_0005, 32'hABAB_ABAB, 4'h2, 2'd0, 32'h0);
        run_txn("sw",  1'b0, 1'b1, 3'd2, 1'b0, 32'hA000_0008, 32'h55AA_1234, 32'h0,
                32'h0000_0008, 32'h55AA_1234, 4'hF, 2'd2, 32'h0);
        run_txn("lw",  1'b1, 1'b0, 3'd2, 1'b0, 32'hC000_0010, 32'h0, 32'h0102_0304,
                32'hC000_0010, 32'h0, 4'h0, 2'd2, 32'h0102_0304);

`ifdef MEM_UNALIGNED_EN
        run_txn("lwl", 1'b1, 1'b0, 3'd4, 1'b0, 32'h0000_0002, 32'h1122_3344, 32'hAABB_CCDD,
                32'h0000_0000, 32'h0, 4'h0, 2'd2, 32'hBBCC_DD44);
        run_txn("lwr", 1'b1, 1'b0, 3'd5, 1'b0, 32'h0000_0001, 32'h1122_3344, 32'hAABB_CCDD,
                32'h0000_0000, 32'h0, 4'h0, 2'd2, 32'h11AA_BBCC);
        run_txn("swl", 1'b0, 1'b1, 3'd4, 1'b0, 32'h0000_0001, 32'h1122_3344, 32'h0,
                32'h0000_0000, 32'h0000_1122, 4'h3, 2'd2, 32'h0);
        run_txn("swr", 1'b0, 1'b1, 3'd5, 1'b0, 32'h0000_0001, 32'h1122_3344, 32'h0,
                32'h0000_0000, 32'h2233_4400, 4'hE, 2'd2, 32'h0);
`else
        drive(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0000_0003, 32'h0);
        #1;
        check("lwl_off_stall", 32'(stall),         32'd0);
        check("lwl_off_err",   32'(addr_err_load), 32'd0);
        @(negedge clk);
        #1;
        check("lwl_off_req",    32'(data_req),    32'd0);
        check("lwl_off_rvalid", 32'(rdata_valid), 32'd0);
        idle();
        @(negedge clk);
`endif

        // Reserved size 3 is never accepted
        drive(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 32'h0000_0000, 32'h0);
        #1;
        check("rsv_stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        check("rsv_req", 32'(data_req), 32'd0);
        idle();
        @(negedge clk);

        // Reset in the middle of a request
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0000_0050, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_req_c1", 32'(data_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("mrst_req_c2",   32'(data_req), 32'd0);
        check("mrst_stall_c2", 32'(stall),    32'd0);
        @(negedge clk);
        #1;
        check("mrst_rvalid", 32'(rdata_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
